// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small synchronous FIFO. Frames are 1 start bit,
// DW data bits (LSB first), optional odd/even parity and one or two stop bits.
module uart_tx_fifo #(
    parameter int  DW           = 8,
    parameter real CLOCK        = 100e6,
    parameter real BAUD_RATE    = 10e6,
    parameter int  BAUD_COUNTER = int'(CLOCK / BAUD_RATE),
    parameter int  DEPTH        = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [DW-1:0]            data_i,
    input  logic                     valid_i,
    output logic                     ready_o,
    input  logic [1:0]               parity_mode_i,
    input  logic                     two_stop_i,
    output logic                     Tx,
    output logic                     busy_o,
    output logic [$clog2(DEPTH):0]   fifo_count_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int BW = (BAUD_COUNTER > 1) ? $clog2(BAUD_COUNTER) : 1;
    localparam int CW = $clog2(DW);

    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_COUNTER - 1);
    localparam logic [BW-1:0] BAUD_ONE  = BW'(1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(DW - 1);
    localparam logic [CW-1:0] BIT_ONE   = CW'(1);
    localparam logic [AW:0]   CNT_FULL  = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);

    if (BAUD_COUNTER < 2) begin : g_bad_baud
        $error("uart_tx_fifo: BAUD_COUNTER must be at least 2");
    end
    if (DW < 5 || DW > 9) begin : g_bad_dw
        $error("uart_tx_fifo: DW must be in 5..9");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_fifo: DEPTH must be a power of two, at least 2");
    end

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_full;

    state_t        r_state;
    logic [BW-1:0] r_baud;
    logic [CW-1:0] r_bit;
    logic [DW-1:0] r_shift;
    logic          r_par_en;
    logic          r_par_bit;
    logic          r_two_stop;
    logic          r_tx;
    logic          r_busy;

    logic          w_push;
    logic          w_pop;
    logic          w_baud_done;
    logic          w_stop_end;
    logic [DW-1:0] w_head;
    logic [AW:0]   w_count_nxt;

    assign ready_o      = ~r_full;
    assign fifo_count_o = r_count;
    assign Tx           = r_tx;
    assign busy_o       = r_busy;

    assign w_push      = valid_i & ~r_full;
    assign w_baud_done = (r_baud == BAUD_LAST);
    assign w_stop_end  = (r_state == STOP) && w_baud_done && (!r_two_stop || r_bit != '0);
    // Pop only from the registered count, so a word written this edge waits one cycle.
    assign w_pop       = (r_count != '0) && ((r_state == IDLE) || w_stop_end);
    assign w_head      = r_mem[r_rd_ptr];

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CNT_ONE;
            2'b01:   w_count_nxt = r_count - CNT_ONE;
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= data_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == CNT_FULL);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= IDLE;
            r_baud     <= '0;
            r_bit      <= '0;
            r_shift    <= '0;
            r_par_en   <= 1'b0;
            r_par_bit  <= 1'b0;
            r_two_stop <= 1'b0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
        end else if (w_pop) begin
            // Frame settings are captured with the word so later changes wait a frame.
            r_state    <= START;
            r_baud     <= '0;
            r_bit      <= '0;
            r_shift    <= w_head;
            r_par_en   <= parity_mode_i[0] ^ parity_mode_i[1];
            r_par_bit  <= (parity_mode_i == 2'd1) ? ~^w_head : ^w_head;
            r_two_stop <= two_stop_i;
            r_tx       <= 1'b0;
            r_busy     <= 1'b1;
        end else begin
            r_baud <= r_baud + BAUD_ONE;
            case (r_state)
                IDLE: begin
                    r_baud <= '0;
                    r_tx   <= 1'b1;
                    r_busy <= 1'b0;
                end
                START: begin
                    if (w_baud_done) begin
                        r_baud  <= '0;
                        r_bit   <= '0;
                        r_state <= DATA;
                        r_tx    <= r_shift[0];
                    end
                end
                DATA: begin
                    if (w_baud_done) begin
                        r_baud <= '0;
                        if (r_bit == BIT_LAST) begin
                            r_bit <= '0;
                            if (r_par_en) begin
                                r_state <= PARITY;
                                r_tx    <= r_par_bit;
                            end else begin
                                r_state <= STOP;
                                r_tx    <= 1'b1;
                            end
                        end else begin
                            r_bit   <= r_bit + BIT_ONE;
                            r_shift <= r_shift >> 1;
                            r_tx    <= r_shift[1];
                        end
                    end
                end
                PARITY: begin
                    if (w_baud_done) begin
                        r_baud  <= '0;
                        r_bit   <= '0;
                        r_state <= STOP;
                        r_tx    <= 1'b1;
                    end
                end
                STOP: begin
                    if (w_baud_done) begin
                        r_baud <= '0;
                        if (r_two_stop && r_bit == '0) begin
                            r_bit <= BIT_ONE;
                        end else begin
                            r_bit   <= '0;
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                        r_tx <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a queue-based line model checked every cycle,
// plus directed frames whose bit patterns are written out by hand.
module tb_uart_tx_fifo;

    localparam int DW    = 8;
    localparam int B     = 10;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data = 8'h00;
    logic       valid = 1'b0;
    logic [1:0] mode = 2'd0;
    logic       two_stop = 1'b0;
    logic       ready;
    logic       tx;
    logic       busy;
    logic [2:0] cnt;

    int tests = 0;
    int fails = 0;

    // Model state: words waiting in the FIFO, and the line level for every
    // remaining cycle of the frame in flight (head = current cycle).
    logic [7:0] fq[$];
    logic       lq[$];
    logic       m_full;
    logic [7:0] m_w;

    uart_tx_fifo #(.DW(DW), .BAUD_COUNTER(B), .DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_i(rst), .data_i(data), .valid_i(valid), .ready_o(ready),
        .parity_mode_i(mode), .two_stop_i(two_stop), .Tx(tx), .busy_o(busy),
        .fifo_count_o(cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            fq.delete();
            lq.delete();
        end else begin
            m_full = (fq.size() == DEPTH);
            if (lq.size() != 0) void'(lq.pop_front());
            if (lq.size() == 0 && fq.size() != 0) begin
                m_w = fq.pop_front();
                repeat (B) lq.push_back(1'b0);
                for (int i = 0; i < DW; i++) repeat (B) lq.push_back(m_w[i]);
                if (mode == 2'd1)      repeat (B) lq.push_back(~^m_w);
                else if (mode == 2'd2) repeat (B) lq.push_back(^m_w);
                repeat (B * (two_stop ? 2 : 1)) lq.push_back(1'b1);
            end
            if (valid && !m_full) fq.push_back(data);
        end
    end

    always @(negedge clk) begin
        check("tx",    32'(tx),    32'((lq.size() != 0) ? lq[0] : 1'b1));
        check("busy",  32'(busy),  32'(lq.size() != 0));
        check("count", 32'(cnt),   32'(fq.size()));
        check("ready", 32'(ready), 32'(fq.size() != DEPTH));
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Records busy length and Tx at mid-bit for every bit slot of the burst.
    task automatic capture(output logic [31:0] bits, output int len);
        int t;
        bits = '0;
        len  = 0;
        t    = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!busy && t < 2000);
        if (!busy) check("capture_start_timeout", 32'(busy), 32'd1);
        while (busy && len < 2000) begin
            if (len % B == B / 2 && len / B < 32) bits[len / B] = tx;
            len++;
            @(negedge clk);
        end
    endtask

    task automatic wait_idle(input int budget);
        int t;
        t = 0;
        while ((busy || cnt != 0) && t < budget) begin
            tick;
            t++;
        end
        check("idle_timeout", 32'(busy || cnt != 0), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] bits;
        int          len;
        int          nb;
        int          t;

        repeat (3) tick;
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_count", 32'(cnt), 32'd0);
        rst = 1'b0;
        tick;

        // 0xA5, no parity, one stop bit
        mode = 2'd0;
        two_stop = 1'b0;
        fork
            capture(bits, len);
            begin
                data = 8'hA5; valid = 1'b1; tick; valid = 1'b0;
            end
        join
        check("a5_len", 32'(len), 32'd100);
        check("a5_bits", 32'(bits[9:0]), 32'b1101001010);

        // 0x07 odd parity then 0x07 even parity, back to back
        mode = 2'd1;
        fork
            capture(bits, len);
            begin
                data = 8'h07; valid = 1'b1; tick; tick; valid = 1'b0; tick; mode = 2'd2;
            end
        join
        check("par_len", 32'(len), 32'd220);
        check("par_bits", 32'(bits[21:0]), 32'b11000001110_10000001110);
        mode = 2'd0;

        // two stop bits on the first frame, one on the second
        two_stop = 1'b1;
        fork
            capture(bits, len);
            begin
                data = 8'h55; valid = 1'b1; tick; tick; valid = 1'b0; tick; two_stop = 1'b0;
            end
        join
        check("stop2_len", 32'(len), 32'd210);
        check("stop2_bits", 32'(bits[20:0]), 32'b1010101010_11010101010);

        // hold valid until the FIFO fills; the surplus words are refused
        valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            data = 8'(8'h10 + i);
            tick;
        end
        check("fill_count", 32'(cnt), 32'd4);
        check("fill_ready", 32'(ready), 32'd0);
        data = 8'hEE;
        t = 0;
        while (cnt == 3'd4 && t < 300) begin
            tick;
            t++;
        end
        valid = 1'b0;
        check("full_pop_count", 32'(cnt), 32'd3);
        wait_idle(2000);

        // reset during data bit 4 with three words queued
        valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            data = 8'(8'h30 + i);
            tick;
        end
        valid = 1'b0;
        check("pre_rst_count", 32'(cnt), 32'd3);
        repeat (B + 4 * B - 2 + B / 2) tick;
        rst = 1'b1;
        #1;
        check("mid_rst_tx", 32'(tx), 32'd1);
        check("mid_rst_count", 32'(cnt), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        tick;
        tick;
        rst = 1'b0;
        nb = 0;
        for (int i = 0; i < 300; i++) begin
            tick;
            if (busy) nb++;
        end
        check("post_rst_quiet", 32'(nb), 32'd0);

        // randomized traffic with settings changing mid-frame
        for (int i = 0; i < 4000; i++) begin
            valid    = ($urandom_range(4) == 0);
            data     = 8'($urandom);
            mode     = 2'($urandom_range(3));
            two_stop = 1'($urandom_range(1));
            if (i == 2000) rst = 1'b1;
            if (i == 2002) rst = 1'b0;
            tick;
        end
        valid = 1'b0;
        wait_idle(3000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
